// File: rtl/icache_pkg.sv
// Shared instruction-cache refill types and default geometry.
// The width localparams describe the default address split
// (offset | bank select | set within bank | tag) used by the refill
// engine, the data array and the tag array.
package icache_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_REQ   = 3'd1,
      ST_RECV  = 3'd2,
      ST_DRAIN = 3'd3,
      ST_WRITE = 3'd4
   } refill_state_e;

   localparam int unsigned DEF_NUM_WAYS            = 32'd4;
   localparam int unsigned DEF_NUM_BANKS           = 32'd4;
   localparam int unsigned DEF_SETS_PER_BANK_WIDTH = 32'd8;
   localparam int unsigned DEF_BLOCK_WIDTH         = 32'd512;
   localparam int unsigned DEF_BEAT_WIDTH          = 32'd64;
   localparam int unsigned DEF_ADDR_WIDTH          = 32'd32;

   localparam int unsigned DEF_OFFSET_W   = $clog2(DEF_BLOCK_WIDTH / 32'd8);
   localparam int unsigned DEF_BANK_SEL_W = $clog2(DEF_NUM_BANKS);
   localparam int unsigned DEF_SET_W      = DEF_SETS_PER_BANK_WIDTH;
   localparam int unsigned DEF_TAG_W      = DEF_ADDR_WIDTH - DEF_OFFSET_W
                                            - DEF_BANK_SEL_W - DEF_SET_W;
   localparam int unsigned DEF_NUM_BEATS  = DEF_BLOCK_WIDTH / DEF_BEAT_WIDTH;

endpackage

// File: rtl/icache_line_buffer.sv
// Beat-indexed line assembly buffer. Each written beat lands in its own
// slot of the line; unwritten slots keep their previous contents.
module icache_line_buffer
   import icache_pkg::*;
#(
   parameter int unsigned BLOCK_WIDTH = DEF_BLOCK_WIDTH,
   parameter int unsigned BEAT_WIDTH  = DEF_BEAT_WIDTH,
   parameter int unsigned IDX_WIDTH   = $clog2(BLOCK_WIDTH / BEAT_WIDTH)
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic                   we_i,
   input  logic [IDX_WIDTH-1:0]   idx_i,
   input  logic [BEAT_WIDTH-1:0]  data_i,
   output logic [BLOCK_WIDTH-1:0] line_o
);

   logic [BLOCK_WIDTH-1:0] line_d;
   logic [BLOCK_WIDTH-1:0] line_q;

   // Merge the incoming beat into its slot of the line
   always_comb begin
      line_d = line_q;
      if (we_i) begin
         line_d[int'(idx_i) * int'(BEAT_WIDTH) +: BEAT_WIDTH] = data_i;
      end else begin
         line_d = line_q;
      end
   end

   // Line storage, cleared on reset
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         line_q <= '0;
      end else begin
         line_q <= line_d;
      end
   end

   assign line_o = line_q;

endmodule

// File: rtl/icache_refill.sv
// Instruction-cache line refill engine: accepts a miss, issues one line
// request, collects the response beats into a line buffer and performs a
// single-cycle data/tag write into the victim way. Protocol errors (error
// beats, early or missing last) end the refill with an error pulse and no
// array write.
module icache_refill
   import icache_pkg::*;
#(
   parameter int unsigned NUM_WAYS            = DEF_NUM_WAYS,
   parameter int unsigned NUM_BANKS           = DEF_NUM_BANKS,
   parameter int unsigned SETS_PER_BANK_WIDTH = DEF_SETS_PER_BANK_WIDTH,
   parameter int unsigned BLOCK_WIDTH         = DEF_BLOCK_WIDTH,
   parameter int unsigned BEAT_WIDTH          = DEF_BEAT_WIDTH,
   parameter int unsigned ADDR_WIDTH          = DEF_ADDR_WIDTH
) (
   input  logic                           clk_i,
   input  logic                           rst_ni,
   input  logic                           miss_valid_i,
   output logic                           miss_ready_o,
   input  logic [ADDR_WIDTH-1:0]          miss_paddr_i,
   input  logic [NUM_WAYS-1:0]            miss_victim_way_i,
   output logic                           mem_req_valid_o,
   input  logic                           mem_req_ready_i,
   output logic [ADDR_WIDTH-1:0]          mem_req_addr_o,
   input  logic                           mem_rsp_valid_i,
   output logic                           mem_rsp_ready_o,
   input  logic [BEAT_WIDTH-1:0]          mem_rsp_data_i,
   input  logic                           mem_rsp_last_i,
   input  logic                           mem_rsp_err_i,
   output logic [SETS_PER_BANK_WIDTH-1:0] w_bank_addr_o,
   output logic [$clog2(NUM_BANKS)-1:0]   w_bank_sel_o,
   output logic [NUM_WAYS-1:0]            we_way_mask_o,
   output logic [BLOCK_WIDTH-1:0]         wdata_o,
   output logic                           tag_we_o,
   output logic [ADDR_WIDTH-$clog2(BLOCK_WIDTH/8)-$clog2(NUM_BANKS)-SETS_PER_BANK_WIDTH-1:0] tag_o,
   output logic                           busy_o,
   output logic                           refill_done_o,
   output logic                           refill_err_o
);

   localparam int unsigned OFF_W  = $clog2(BLOCK_WIDTH / 8);
   localparam int unsigned BANK_W = $clog2(NUM_BANKS);
   localparam int unsigned SET_W  = SETS_PER_BANK_WIDTH;
   localparam int unsigned TAG_W  = ADDR_WIDTH - OFF_W - BANK_W - SET_W;
   localparam int unsigned BEATS  = BLOCK_WIDTH / BEAT_WIDTH;
   localparam int unsigned CNT_W  = $clog2(BEATS);

   localparam logic [CNT_W-1:0]      LAST_BEAT = CNT_W'(BEATS - 1);
   localparam logic [ADDR_WIDTH-1:0] LINE_MASK = ~((ADDR_WIDTH'(1) << OFF_W) - ADDR_WIDTH'(1));
   localparam logic [NUM_WAYS-1:0]   WAY0      = NUM_WAYS'(1);

   refill_state_e           state_d, state_q;
   logic [CNT_W-1:0]        cnt_d, cnt_q;
   logic                    err_d, err_q;
   logic [ADDR_WIDTH-1:0]   paddr_d, paddr_q;
   logic [NUM_WAYS-1:0]     way_d, way_q;

   logic                    miss_ready_d, miss_ready_q;
   logic                    busy_d, busy_q;
   logic                    mem_req_valid_d, mem_req_valid_q;
   logic                    mem_rsp_ready_d, mem_rsp_ready_q;
   logic [NUM_WAYS-1:0]     we_way_mask_d, we_way_mask_q;
   logic                    tag_we_d, tag_we_q;
   logic                    refill_done_d, refill_done_q;
   logic                    refill_err_d, refill_err_q;

   logic                    buf_we_s;
   logic                    err_now_s;
   logic                    err_pulse_s;
   logic [NUM_WAYS-1:0]     way_pick_s;

   // Next-state, latched fields and next registered-output values
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      err_d       = err_q;
      paddr_d     = paddr_q;
      way_d       = way_q;
      buf_we_s    = 1'b0;
      err_pulse_s = 1'b0;
      err_now_s   = err_q | mem_rsp_err_i;
      // Isolate the lowest set victim bit (two's-complement trick)
      way_pick_s  = miss_victim_way_i & (~miss_victim_way_i + NUM_WAYS'(1));

      case (state_q)
         ST_IDLE: begin
            if (miss_valid_i) begin
               paddr_d = miss_paddr_i & LINE_MASK;
               if (way_pick_s == '0) begin
                  way_d = WAY0;
               end else begin
                  way_d = way_pick_s;
               end
               cnt_d   = '0;
               err_d   = 1'b0;
               state_d = ST_REQ;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_REQ: begin
            if (mem_req_ready_i) begin
               state_d = ST_RECV;
            end else begin
               state_d = ST_REQ;
            end
         end
         ST_RECV: begin
            if (mem_rsp_valid_i) begin
               buf_we_s = 1'b1;
               err_d    = err_now_s;
               if (cnt_q == LAST_BEAT) begin
                  if (!mem_rsp_last_i) begin
                     // Line is full but the response continues: flush it
                     err_d   = 1'b1;
                     state_d = ST_DRAIN;
                  end else if (err_now_s) begin
                     err_pulse_s = 1'b1;
                     state_d     = ST_IDLE;
                  end else begin
                     state_d = ST_WRITE;
                  end
               end else if (mem_rsp_last_i) begin
                  // Response ended before the line was complete
                  err_d       = 1'b1;
                  err_pulse_s = 1'b1;
                  state_d     = ST_IDLE;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end else begin
               state_d = ST_RECV;
            end
         end
         ST_DRAIN: begin
            if (mem_rsp_valid_i && mem_rsp_last_i) begin
               err_pulse_s = 1'b1;
               state_d     = ST_IDLE;
            end else begin
               state_d = ST_DRAIN;
            end
         end
         ST_WRITE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      miss_ready_d    = (state_d == ST_IDLE);
      busy_d          = (state_d != ST_IDLE);
      mem_req_valid_d = (state_d == ST_REQ);
      mem_rsp_ready_d = (state_d == ST_RECV) || (state_d == ST_DRAIN);
      tag_we_d        = (state_d == ST_WRITE);
      refill_done_d   = (state_d == ST_WRITE);
      refill_err_d    = err_pulse_s;
      if (state_d == ST_WRITE) begin
         we_way_mask_d = way_d;
      end else begin
         we_way_mask_d = '0;
      end
   end

   // FSM state, counters, latched miss fields and registered outputs
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q         <= ST_IDLE;
         cnt_q           <= '0;
         err_q           <= 1'b0;
         paddr_q         <= '0;
         way_q           <= '0;
         miss_ready_q    <= 1'b1;
         busy_q          <= 1'b0;
         mem_req_valid_q <= 1'b0;
         mem_rsp_ready_q <= 1'b0;
         we_way_mask_q   <= '0;
         tag_we_q        <= 1'b0;
         refill_done_q   <= 1'b0;
         refill_err_q    <= 1'b0;
      end else begin
         state_q         <= state_d;
         cnt_q           <= cnt_d;
         err_q           <= err_d;
         paddr_q         <= paddr_d;
         way_q           <= way_d;
         miss_ready_q    <= miss_ready_d;
         busy_q          <= busy_d;
         mem_req_valid_q <= mem_req_valid_d;
         mem_rsp_ready_q <= mem_rsp_ready_d;
         we_way_mask_q   <= we_way_mask_d;
         tag_we_q        <= tag_we_d;
         refill_done_q   <= refill_done_d;
         refill_err_q    <= refill_err_d;
      end
   end

   icache_line_buffer #(
      .BLOCK_WIDTH (BLOCK_WIDTH),
      .BEAT_WIDTH  (BEAT_WIDTH),
      .IDX_WIDTH   (CNT_W)
   ) u_line_buffer (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .we_i   (buf_we_s),
      .idx_i  (cnt_q),
      .data_i (mem_rsp_data_i),
      .line_o (wdata_o)
   );

   assign miss_ready_o    = miss_ready_q;
   assign busy_o          = busy_q;
   assign mem_req_valid_o = mem_req_valid_q;
   assign mem_rsp_ready_o = mem_rsp_ready_q;
   assign we_way_mask_o   = we_way_mask_q;
   assign tag_we_o        = tag_we_q;
   assign refill_done_o   = refill_done_q;
   assign refill_err_o    = refill_err_q;
   assign mem_req_addr_o  = paddr_q;
   assign w_bank_sel_o    = paddr_q[OFF_W +: BANK_W];
   assign w_bank_addr_o   = paddr_q[OFF_W + BANK_W +: SET_W];
   assign tag_o           = paddr_q[ADDR_WIDTH-1 -: TAG_W];

endmodule

// File: tb/tb_icache_refill.sv
// Directed + randomized bench for icache_refill with a transaction-level
// reference model: outcome, write mask, line contents, address fields and
// write latency are derived from the refill rules with plain arithmetic.
module tb_icache_refill;
   import icache_pkg::*;

   localparam int NW    = DEF_NUM_WAYS;
   localparam int AW    = DEF_ADDR_WIDTH;
   localparam int BW    = DEF_BLOCK_WIDTH;
   localparam int BTW   = DEF_BEAT_WIDTH;
   localparam int NBT   = DEF_NUM_BEATS;
   localparam int LINEB = BW / 8;

   logic                      clk;
   logic                      rst_ni;
   logic                      miss_valid_i;
   logic                      miss_ready_o;
   logic [AW-1:0]             miss_paddr_i;
   logic [NW-1:0]             miss_victim_way_i;
   logic                      mem_req_valid_o;
   logic                      mem_req_ready_i;
   logic [AW-1:0]             mem_req_addr_o;
   logic                      mem_rsp_valid_i;
   logic                      mem_rsp_ready_o;
   logic [BTW-1:0]            mem_rsp_data_i;
   logic                      mem_rsp_last_i;
   logic                      mem_rsp_err_i;
   logic [DEF_SET_W-1:0]      w_bank_addr_o;
   logic [DEF_BANK_SEL_W-1:0] w_bank_sel_o;
   logic [NW-1:0]             we_way_mask_o;
   logic [BW-1:0]             wdata_o;
   logic                      tag_we_o;
   logic [DEF_TAG_W-1:0]      tag_o;
   logic                      busy_o;
   logic                      refill_done_o;
   logic                      refill_err_o;

   int n_checks = 0;
   int n_pass   = 0;

   icache_refill dut (
      .clk_i             (clk),
      .rst_ni            (rst_ni),
      .miss_valid_i      (miss_valid_i),
      .miss_ready_o      (miss_ready_o),
      .miss_paddr_i      (miss_paddr_i),
      .miss_victim_way_i (miss_victim_way_i),
      .mem_req_valid_o   (mem_req_valid_o),
      .mem_req_ready_i   (mem_req_ready_i),
      .mem_req_addr_o    (mem_req_addr_o),
      .mem_rsp_valid_i   (mem_rsp_valid_i),
      .mem_rsp_ready_o   (mem_rsp_ready_o),
      .mem_rsp_data_i    (mem_rsp_data_i),
      .mem_rsp_last_i    (mem_rsp_last_i),
      .mem_rsp_err_i     (mem_rsp_err_i),
      .w_bank_addr_o     (w_bank_addr_o),
      .w_bank_sel_o      (w_bank_sel_o),
      .we_way_mask_o     (we_way_mask_o),
      .wdata_o           (wdata_o),
      .tag_we_o          (tag_we_o),
      .tag_o             (tag_o),
      .busy_o            (busy_o),
      .refill_done_o     (refill_done_o),
      .refill_err_o      (refill_err_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #600000;
      $display("FAIL watchdog: observed no end of test, expected finish before time limit");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // Victim selection rule: lowest set bit, way 0 when none is set
   function automatic logic [NW-1:0] exp_mask(input logic [NW-1:0] v);
      for (int i = 0; i < NW; i++) begin
         if (v[i]) return NW'(1) << i;
      end
      return NW'(1);
   endfunction

   task automatic check_reset_outputs();
      check("rst_miss_ready", miss_ready_o, 1'b1);
      check("rst_busy", busy_o, 1'b0);
      check("rst_req_valid", mem_req_valid_o, 1'b0);
      check("rst_req_addr", mem_req_addr_o, '0);
      check("rst_rsp_ready", mem_rsp_ready_o, 1'b0);
      check("rst_we", {tag_we_o, we_way_mask_o}, '0);
      check("rst_pulses", {refill_done_o, refill_err_o}, '0);
      check("rst_fields", {tag_o, w_bank_addr_o, w_bank_sel_o}, '0);
      check("rst_wdata", wdata_o, '0);
   endtask

   // One refill transaction. last_at: index of the beat carrying last;
   // err_at: index of a beat with err (-1 none); abort_beat: beat during
   // which reset is asserted (-1 none).
   task automatic run_refill(input logic [AW-1:0] paddr, input logic [NW-1:0] victim,
                             input int req_stall, input int last_at, input int err_at,
                             input int gap_pct, input int abort_beat, input bit fixed_data);
      logic [BTW-1:0] beats[$];
      logic [BW-1:0]  exp_line;
      logic [AW-1:0]  line_addr;
      int             gaps;
      int             cyc;
      int             sent;
      bit             exp_ok;
      beats    = {};
      exp_line = '0;
      for (int i = 0; i <= last_at; i++) begin
         if (fixed_data) beats.push_back(BTW'((i + 1) * 17));
         else            beats.push_back({$urandom, $urandom});
      end
      for (int i = 0; i < NBT && i <= last_at; i++) begin
         exp_line = exp_line | ({{(BW-BTW){1'b0}}, beats[i]} << (i * BTW));
      end
      exp_ok    = (last_at == NBT - 1) && !(err_at >= 0 && err_at < NBT);
      line_addr = paddr - (paddr % LINEB);

      @(negedge clk);
      check("idle_ready", miss_ready_o, 1'b1);
      miss_valid_i      = 1'b1;
      miss_paddr_i      = paddr;
      miss_victim_way_i = victim;
      @(negedge clk);
      cyc               = 1;
      miss_valid_i      = 1'b0;
      miss_paddr_i      = $urandom;
      miss_victim_way_i = NW'($urandom);

      for (int s = 0; s <= req_stall; s++) begin
         check("req_valid", mem_req_valid_o, 1'b1);
         check("req_addr", mem_req_addr_o, line_addr);
         check("req_busy", {busy_o, miss_ready_o}, 2'b10);
         mem_req_ready_i = (s == req_stall);
         @(negedge clk);
         cyc++;
      end
      mem_req_ready_i = 1'b0;

      sent = 0;
      gaps = 0;
      while (sent <= last_at) begin
         check("rsp_ready", mem_rsp_ready_o, 1'b1);
         check("no_write", {tag_we_o, we_way_mask_o, refill_done_o}, '0);
         if (gaps < 6 && int'($urandom_range(99)) < gap_pct) begin
            mem_rsp_valid_i = 1'b0;
            mem_rsp_data_i  = {$urandom, $urandom};
            mem_rsp_last_i  = 1'($urandom);
            mem_rsp_err_i   = 1'($urandom);
            gaps++;
         end else begin
            mem_rsp_valid_i = 1'b1;
            mem_rsp_data_i  = beats[sent];
            mem_rsp_last_i  = (sent == last_at);
            mem_rsp_err_i   = (sent == err_at);
            if (sent == abort_beat) begin
               rst_ni = 1'b0;
               @(negedge clk);
               check_reset_outputs();
               mem_rsp_valid_i = 1'b0;
               mem_rsp_last_i  = 1'b0;
               mem_rsp_err_i   = 1'b0;
               @(negedge clk);
               check_reset_outputs();
               rst_ni = 1'b1;
               return;
            end
            sent++;
         end
         @(negedge clk);
         cyc++;
      end
      mem_rsp_valid_i = 1'b0;
      mem_rsp_last_i  = 1'b0;
      mem_rsp_err_i   = 1'b0;

      if (exp_ok) begin
         check("write_cycle", cyc, 10 + req_stall + gaps);
         check("we_mask", we_way_mask_o, exp_mask(victim));
         check("write_flags", {tag_we_o, refill_done_o, refill_err_o, busy_o, miss_ready_o}, 5'b11010);
         check("wdata", wdata_o, exp_line);
         check("tag", tag_o, paddr / (LINEB * 4 * 256));
         check("bank_sel", w_bank_sel_o, (paddr / LINEB) % 4);
         check("bank_addr", w_bank_addr_o, (paddr / (LINEB * 4)) % 256);
      end else begin
         check("err_flags", {refill_err_o, refill_done_o, tag_we_o, busy_o, miss_ready_o}, 5'b10001);
         check("err_no_we", we_way_mask_o, '0);
      end
      @(negedge clk);
      check("pulse_clear", {refill_done_o, refill_err_o, tag_we_o, we_way_mask_o}, '0);
      check("ready_after", {miss_ready_o, busy_o}, 2'b10);
   endtask

   initial begin
      rst_ni            = 1'b0;
      miss_valid_i      = 1'b0;
      miss_paddr_i      = '0;
      miss_victim_way_i = '0;
      mem_req_ready_i   = 1'b0;
      mem_rsp_valid_i   = 1'b0;
      mem_rsp_data_i    = '0;
      mem_rsp_last_i    = 1'b0;
      mem_rsp_err_i     = 1'b0;
      repeat (3) @(negedge clk);
      check_reset_outputs();
      rst_ni = 1'b1;

      // Back-to-back reference refill with known beat data
      run_refill(32'h0001_2340, 4'b0100, 0, 7, -1, 0, -1, 1'b1);
      check("s1_bank_sel", w_bank_sel_o, 2'd1);
      check("s1_bank_addr", w_bank_addr_o, 8'h23);
      check("s1_tag", tag_o, 16'h0001);
      check("s1_beat0", wdata_o[BTW-1:0], 64'h11);

      // Request stall and gappy response
      run_refill(32'hDEAD_BEEF, 4'b1000, 5, 7, -1, 40, -1, 1'b0);
      // Error beat mid-line
      run_refill(32'h1234_5678, 4'b0010, 1, 7, 3, 20, -1, 1'b0);
      // Early last, then missing last with drain
      run_refill(32'h0F0F_0F00, 4'b0001, 0, 5, -1, 0, -1, 1'b0);
      run_refill(32'h7654_3210, 4'b0100, 2, 10, -1, 30, -1, 1'b0);
      // Reset during beat 4, then a clean refill
      run_refill(32'hCAFE_0040, 4'b1000, 0, 7, -1, 0, 4, 1'b0);
      run_refill(32'h0BAD_F0C0, 4'b0100, 0, 7, -1, 0, -1, 1'b0);
      // Victim way selection corner cases
      run_refill(32'h4000_0080, 4'b0000, 0, 7, -1, 0, -1, 1'b0);
      run_refill(32'h4000_0100, 4'b1010, 0, 7, -1, 0, -1, 1'b0);

      // Randomized refills
      for (int r = 0; r < 12; r++) begin
         int la;
         int ea;
         la = ($urandom_range(3) == 0) ? int'($urandom_range(10)) : 7;
         ea = ($urandom_range(4) == 0) ? int'($urandom_range(7)) : -1;
         run_refill($urandom, NW'($urandom), int'($urandom_range(3)), la, ea,
                    int'($urandom_range(50)), -1, 1'b0);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/icache_refill.md
ICACHE_REFILL -- requirements
Module: icache_refill

Interface
REQ-001 SHALL take parameter NUM_WAYS, default 4, the number of cache ways.
REQ-002 SHALL take parameter NUM_BANKS, default 4, the number of data-array banks.
REQ-003 SHALL take parameter SETS_PER_BANK_WIDTH, default 8, the set-index width within a bank.
REQ-004 SHALL take parameter BLOCK_WIDTH, default 512, the line width in bits.
REQ-005 SHALL take parameter BEAT_WIDTH, default 64, the memory beat width.
REQ-006 SHALL take parameter ADDR_WIDTH, default 32, the physical address width.
REQ-007 clk_i  in  1  single clock; rst_ni  in  1  reset, asynchronous, active-low.
REQ-008 miss_valid_i  in  1  miss request; miss_ready_o  out  1  block idle, accepting.
REQ-009 miss_paddr_i  in  ADDR_WIDTH  miss address; miss_victim_way_i  in  NUM_WAYS  victim way, one-hot.
REQ-010 mem_req_valid_o  out  1; mem_req_ready_i  in  1; mem_req_addr_o  out  ADDR_WIDTH  line-aligned address.
REQ-011 mem_rsp_valid_i  in  1; mem_rsp_ready_o  out  1; mem_rsp_data_i  in  BEAT_WIDTH; mem_rsp_last_i  in  1; mem_rsp_err_i  in  1.
REQ-012 w_bank_addr_o  out  SETS_PER_BANK_WIDTH; w_bank_sel_o  out  log2(NUM_BANKS); we_way_mask_o  out  NUM_WAYS; wdata_o  out  BLOCK_WIDTH.  These drive the data-array write port.
REQ-013 tag_we_o  out  1; tag_o  out  ADDR_WIDTH-log2(BLOCK_WIDTH/8)-log2(NUM_BANKS)-SETS_PER_BANK_WIDTH.  These carry the tag write.
REQ-014 busy_o  out  1; refill_done_o  out  1  one-cycle pulse; refill_err_o  out  1  one-cycle pulse.

Function
REQ-015 The address SHALL split as: offset = low log2(BLOCK_WIDTH/8) bits; bank_sel = next log2(NUM_BANKS) bits; bank_addr = next SETS_PER_BANK_WIDTH bits; tag = remaining bits.
REQ-016 The FSM SHALL have the states IDLE, REQ, RECV, DRAIN and WRITE.
REQ-017 In IDLE, miss_ready_o SHALL be 1; on miss_valid_i&&miss_ready_o the block SHALL latch the address and the way, clear the beat counter and error flag, and go to REQ.
REQ-018 The latched way SHALL be the lowest set bit of miss_victim_way_i; an all-zero input SHALL select way 0.
REQ-019 In REQ, mem_req_valid_o SHALL be 1 with a stable mem_req_addr_o (offset zeroed) until mem_req_ready_i; the state then SHALL go to RECV.
REQ-020 In RECV, mem_rsp_ready_o SHALL be 1; beat k SHALL be stored in wdata bits [k*BEAT_WIDTH +: BEAT_WIDTH], with k counting 0..BLOCK_WIDTH/BEAT_WIDTH-1.
REQ-021 Any beat with mem_rsp_err_i SHALL set the sticky error flag.
REQ-022 A beat with last and k<final SHALL set the error flag and go to IDLE.
REQ-023 When k==final, the state SHALL go to WRITE if last=1 and the error flag is clear.
REQ-024 When k==final and last=1 with the error flag set, the state SHALL go to IDLE.
REQ-025 When k==final and last=0, the block SHALL set the error flag and go to DRAIN.
REQ-026 In DRAIN, mem_rsp_ready_o SHALL be 1 and beats SHALL be discarded until last, then the state SHALL go to IDLE.
REQ-027 WRITE SHALL last exactly one cycle: we_way_mask_o = latched one-hot way, tag_we_o=1, refill_done_o=1; next state IDLE.
REQ-028 Every transition to IDLE on an error SHALL pulse refill_err_o for one cycle, and no data or tag write SHALL occur.
REQ-029 we_way_mask_o and tag_we_o SHALL be 0 outside WRITE.
REQ-030 w_bank_addr_o, w_bank_sel_o and tag_o SHALL always reflect the latched address; wdata_o SHALL reflect the line buffer.
REQ-031 busy_o SHALL equal !IDLE.
REQ-032 Minimum latency: accept at cycle T, with mem ready and one beat per cycle, SHALL give WRITE at T+10 (8 beats) and miss_ready_o at T+11.
REQ-033 Beats with mem_rsp_valid_i=0 SHALL stall the counter without corrupting stored data.

Reset
REQ-034 While rst_ni=0, the state SHALL be IDLE and all outputs, the counter, the buffer, the error flag and the latched fields SHALL be 0, except miss_ready_o=1.
REQ-035 Reset asserted mid-refill SHALL abort immediately, with no write or pulse; the first miss after reset SHALL behave normally.

Structure
REQ-036 Package icache_pkg SHALL hold refill_state_e, the default geometry constants, and the offset/bank/set/tag width localparams shared with data_array and the tag array.
REQ-037 A single sub-module, icache_line_buffer, SHALL be used: it is beat-indexed, write-enabled, cleared on reset, and has the full line as its output.

Verification
REQ-038 Scenario: reset, then miss paddr 0x0001_2340 way 4'b0100, 8 beats 0x11..0x88 back-to-back -> WRITE at T+10, bank_sel=1, bank_addr=0x23, tag=0x0001, mask=4'b0100, wdata beat0=0x11, refill_done_o pulse.
REQ-039 Scenario: mem_req_ready_i held low 5 cycles and rsp_valid toggling -> address stable, data correct, done delayed by the stall count.
REQ-040 Scenario: err on beat 3 -> remaining beats accepted, no we/tag_we, refill_err_o one pulse, back to IDLE.
REQ-041 Scenario: last on beat 5 -> error pulse, IDLE; last missing at beat 7 -> DRAIN until last, then error pulse.
REQ-042 Scenario: rst_ni low during beat 4 -> all outputs 0, miss_ready_o=1; next refill completes correctly.
REQ-043 Scenario: victim way 4'b0000 and 4'b1010 -> masks 4'b0001 and 4'b0010.
